// File: rtl/led_pattern_seq.sv
// led_pattern_seq: multi-channel programmable LED blink sequencer.
// Each channel replays a stored list of (level, duration) segments, either
// once or looping, paced by a single tick shared by all channels.
// led, busy and done are registered; nothing combinational reaches the pins.
module led_pattern_seq #(
    parameter int unsigned CLK_FREQ       = 48_000_000,
    parameter int unsigned TICK_HZ        = 1000,
    parameter int unsigned NUM_CH         = 4,
    parameter int unsigned DEPTH          = 8,
    parameter int unsigned DUR_W          = 16,
    parameter int unsigned LED_ACTIVE_LOW = 1,
    localparam int unsigned CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int unsigned IDX_W         = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_en,
    input  logic [CH_W-1:0]    wr_ch,
    input  logic [IDX_W-1:0]   wr_idx,
    input  logic               wr_level,
    input  logic [DUR_W-1:0]   wr_dur,
    input  logic               cfg_en,
    input  logic [CH_W-1:0]    cfg_ch,
    input  logic [IDX_W:0]     cfg_len,
    input  logic               cfg_repeat,
    input  logic [NUM_CH-1:0]  start,
    input  logic [NUM_CH-1:0]  stop,
    output logic [NUM_CH-1:0]  led,
    output logic [NUM_CH-1:0]  busy,
    output logic [NUM_CH-1:0]  done
);

    localparam int unsigned DIV     = CLK_FREQ / TICK_HZ;
    localparam int unsigned PS_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned LEN_W   = IDX_W + 1;
    localparam logic        LED_OFF = (LED_ACTIVE_LOW != 0);

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } ch_state_t;

    // Prescaler
    logic [PS_W-1:0]   ps_q;
    logic              tick;

    // Pattern memory and per-channel configuration
    logic [DUR_W-1:0]  mem_dur [NUM_CH][DEPTH];
    logic [DEPTH-1:0]  mem_lvl [NUM_CH];
    logic [LEN_W-1:0]  len_q   [NUM_CH];
    logic [NUM_CH-1:0] rep_q;
    logic              wr_ok;
    logic              cfg_ok;

    // Channel sequencer state
    ch_state_t         state_q [NUM_CH];
    ch_state_t         state_d [NUM_CH];
    logic [IDX_W-1:0]  idx_q   [NUM_CH];
    logic [IDX_W-1:0]  idx_d   [NUM_CH];
    logic [DUR_W-1:0]  rem_q   [NUM_CH];
    logic [DUR_W-1:0]  rem_d   [NUM_CH];
    logic [NUM_CH-1:0] load;
    logic [NUM_CH-1:0] load_lvl;
    logic [NUM_CH-1:0] fin;

    // Registered outputs and their next values
    logic [NUM_CH-1:0] led_q;
    logic [NUM_CH-1:0] busy_q;
    logic [NUM_CH-1:0] done_q;
    logic [NUM_CH-1:0] led_d;
    logic [NUM_CH-1:0] busy_d;
    logic [NUM_CH-1:0] done_d;

    // A stored duration of zero still plays for one tick.
    function automatic logic [DUR_W-1:0] eff_dur(input logic [DUR_W-1:0] d);
        return (d == '0) ? DUR_W'(1) : d;
    endfunction

    assign tick   = (ps_q == PS_W'(DIV - 1));
    assign wr_ok  = wr_en && (32'(wr_ch) < NUM_CH) && (32'(wr_idx) < DEPTH);
    assign cfg_ok = cfg_en && (32'(cfg_ch) < NUM_CH) && (32'(cfg_len) <= DEPTH);

    // Free-running prescaler, wraps at DIV-1; tick marks the wrap cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ps_q <= '0;
        end else if (tick) begin
            ps_q <= '0;
        end else begin
            ps_q <= ps_q + PS_W'(1);
        end
    end

    // Pattern memory; writes are accepted at any time, out-of-range ones dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                mem_lvl[c] <= '0;
                for (int unsigned k = 0; k < DEPTH; k++) begin
                    mem_dur[c][k] <= '0;
                end
            end
        end else if (wr_ok) begin
            mem_dur[wr_ch][wr_idx] <= wr_dur;
            mem_lvl[wr_ch][wr_idx] <= wr_level;
        end
    end

    // Per-channel length and repeat mode; lengths above DEPTH are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep_q <= '0;
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                len_q[c] <= '0;
            end
        end else if (cfg_ok) begin
            len_q[cfg_ch] <= cfg_len;
            rep_q[cfg_ch] <= cfg_repeat;
        end
    end

    // Channel state register: FSM state, segment index, remaining ticks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                state_q[c] <= ST_IDLE;
                idx_q[c]   <= '0;
                rem_q[c]   <= '0;
            end
        end else begin
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                state_q[c] <= state_d[c];
                idx_q[c]   <= idx_d[c];
                rem_q[c]   <= rem_d[c];
            end
        end
    end

    // Next-state logic: stop beats start, start beats tick handling.
    // load/load_lvl flag a segment being (re)loaded so its level reaches led.
    always_comb begin
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            state_d[c]  = state_q[c];
            idx_d[c]    = idx_q[c];
            rem_d[c]    = rem_q[c];
            load[c]     = 1'b0;
            load_lvl[c] = 1'b0;
            fin[c]      = 1'b0;
            if (stop[c]) begin
                state_d[c] = ST_IDLE;
            end else if (start[c] && (len_q[c] != '0)) begin
                state_d[c]  = ST_RUN;
                idx_d[c]    = '0;
                rem_d[c]    = eff_dur(mem_dur[c][0]);
                load[c]     = 1'b1;
                load_lvl[c] = mem_lvl[c][0];
            end else if ((state_q[c] == ST_RUN) && tick) begin
                if (rem_q[c] > DUR_W'(1)) begin
                    rem_d[c] = rem_q[c] - DUR_W'(1);
                end else if (({1'b0, idx_q[c]} + LEN_W'(1)) >= len_q[c]) begin
                    // Length is re-read here, so a shrink mid-run ends or wraps now.
                    if (rep_q[c]) begin
                        idx_d[c]    = '0;
                        rem_d[c]    = eff_dur(mem_dur[c][0]);
                        load[c]     = 1'b1;
                        load_lvl[c] = mem_lvl[c][0];
                    end else begin
                        state_d[c] = ST_IDLE;
                        fin[c]     = 1'b1;
                    end
                end else begin
                    idx_d[c]    = idx_q[c] + IDX_W'(1);
                    rem_d[c]    = eff_dur(mem_dur[c][idx_q[c] + IDX_W'(1)]);
                    load[c]     = 1'b1;
                    load_lvl[c] = mem_lvl[c][idx_q[c] + IDX_W'(1)];
                end
            end
        end
    end

    // Output logic: level latched at segment load, OFF whenever idle.
    always_comb begin
        led_d  = led_q;
        busy_d = '0;
        done_d = fin;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            busy_d[c] = (state_d[c] == ST_RUN);
            if (state_d[c] == ST_IDLE) begin
                led_d[c] = LED_OFF;
            end else if (load[c]) begin
                led_d[c] = load_lvl[c] ^ LED_OFF;
            end
        end
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_q  <= {NUM_CH{LED_OFF}};
            busy_q <= '0;
            done_q <= '0;
        end else begin
            led_q  <= led_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign led  = led_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_led_pattern_seq.sv
// tb_led_pattern_seq: scoreboard bench for led_pattern_seq.
// A tick-count based reference model pushes the expected {led,busy,done}
// after every clock edge; a monitor pops and compares on the falling edge.
module tb_led_pattern_seq;

    localparam int unsigned CLK_FREQ = 1000;
    localparam int unsigned TICK_HZ  = 100;
    localparam int unsigned NUM_CH   = 4;
    localparam int unsigned DEPTH    = 8;
    localparam int unsigned DUR_W    = 16;
    localparam int unsigned DIV      = CLK_FREQ / TICK_HZ;
    localparam int unsigned CH_W     = 2;
    localparam int unsigned IDX_W    = 3;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               wr_en = 1'b0;
    logic [CH_W-1:0]    wr_ch = '0;
    logic [IDX_W-1:0]   wr_idx = '0;
    logic               wr_level = 1'b0;
    logic [DUR_W-1:0]   wr_dur = '0;
    logic               cfg_en = 1'b0;
    logic [CH_W-1:0]    cfg_ch = '0;
    logic [IDX_W:0]     cfg_len = '0;
    logic               cfg_repeat = 1'b0;
    logic [NUM_CH-1:0]  start = '0;
    logic [NUM_CH-1:0]  stop = '0;
    logic [NUM_CH-1:0]  led;
    logic [NUM_CH-1:0]  busy;
    logic [NUM_CH-1:0]  done;

    always #5 clk = ~clk;

    led_pattern_seq #(
        .CLK_FREQ      (CLK_FREQ),
        .TICK_HZ       (TICK_HZ),
        .NUM_CH        (NUM_CH),
        .DEPTH         (DEPTH),
        .DUR_W         (DUR_W),
        .LED_ACTIVE_LOW(1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_ch     (wr_ch),
        .wr_idx    (wr_idx),
        .wr_level  (wr_level),
        .wr_dur    (wr_dur),
        .cfg_en    (cfg_en),
        .cfg_ch    (cfg_ch),
        .cfg_len   (cfg_len),
        .cfg_repeat(cfg_repeat),
        .start     (start),
        .stop      (stop),
        .led       (led),
        .busy      (busy),
        .done      (done)
    );

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
        end
    endtask

    // ---------------- reference model ----------------
    logic [DUR_W-1:0]  s_dur [NUM_CH][DEPTH];
    bit                s_lvl [NUM_CH][DEPTH];
    int unsigned       s_len [NUM_CH];
    bit                s_rep [NUM_CH];
    bit                m_run [NUM_CH];
    bit                m_lvl [NUM_CH];
    int unsigned       m_seg [NUM_CH];
    int unsigned       m_end [NUM_CH];
    int unsigned       m_ps;
    int unsigned       m_tn;
    bit                m_tick;
    logic [NUM_CH-1:0] e_led, e_busy, e_done;
    logic [11:0]       exp_q [$];
    logic [11:0]       exp_now;
    int unsigned       done_seen [NUM_CH];

    function automatic int unsigned eff(input logic [DUR_W-1:0] d);
        return (d == '0) ? 1 : 32'(d);
    endfunction

    // Segment ends at an absolute tick number rather than via a countdown.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ps = 0;
            m_tn = 0;
            for (int c = 0; c < NUM_CH; c++) begin
                m_run[c] = 1'b0;
                m_lvl[c] = 1'b0;
                m_seg[c] = 0;
                m_end[c] = 0;
                s_len[c] = 0;
                s_rep[c] = 1'b0;
                for (int k = 0; k < DEPTH; k++) begin
                    s_dur[c][k] = '0;
                    s_lvl[c][k] = 1'b0;
                end
            end
        end else begin
            m_tick = (m_ps == DIV - 1);
            m_ps   = m_tick ? 0 : m_ps + 1;
            if (m_tick) m_tn++;
            e_done = '0;
            for (int c = 0; c < NUM_CH; c++) begin
                if (stop[c]) begin
                    m_run[c] = 1'b0;
                    m_lvl[c] = 1'b0;
                end else if (start[c] && s_len[c] != 0) begin
                    m_run[c] = 1'b1;
                    m_seg[c] = 0;
                    m_lvl[c] = s_lvl[c][0];
                    m_end[c] = m_tn + eff(s_dur[c][0]);
                end else if (m_run[c] && m_tick && m_tn == m_end[c]) begin
                    if (m_seg[c] + 1 >= s_len[c]) begin
                        if (s_rep[c]) begin
                            m_seg[c] = 0;
                            m_lvl[c] = s_lvl[c][0];
                            m_end[c] = m_tn + eff(s_dur[c][0]);
                        end else begin
                            m_run[c]  = 1'b0;
                            m_lvl[c]  = 1'b0;
                            e_done[c] = 1'b1;
                        end
                    end else begin
                        m_seg[c] = m_seg[c] + 1;
                        m_lvl[c] = s_lvl[c][m_seg[c]];
                        m_end[c] = m_tn + eff(s_dur[c][m_seg[c]]);
                    end
                end
                e_led[c]  = m_run[c] ? ~m_lvl[c] : 1'b1;
                e_busy[c] = m_run[c];
            end
            if (wr_en && 32'(wr_ch) < NUM_CH && 32'(wr_idx) < DEPTH) begin
                s_dur[wr_ch][wr_idx] = wr_dur;
                s_lvl[wr_ch][wr_idx] = wr_level;
            end
            if (cfg_en && 32'(cfg_ch) < NUM_CH && 32'(cfg_len) <= DEPTH) begin
                s_len[cfg_ch] = 32'(cfg_len);
                s_rep[cfg_ch] = cfg_repeat;
            end
            exp_q.push_back({e_led, e_busy, e_done});
        end
    end

    // Monitor: compare DUT outputs against the scoreboard on the falling edge.
    initial begin
        for (int c = 0; c < NUM_CH; c++) done_seen[c] = 0;
        forever begin
            @(negedge clk);
            for (int c = 0; c < NUM_CH; c++) begin
                if (done[c]) done_seen[c]++;
            end
            if (exp_q.size() > 0) begin
                exp_now = exp_q.pop_front();
                check_val("outs{led,busy,done}", 32'({led, busy, done}), 32'(exp_now));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic write_seg(input int ch, input int idx, input bit lvl, input int dur);
        @(negedge clk);
        wr_en = 1'b1; wr_ch = CH_W'(ch); wr_idx = IDX_W'(idx);
        wr_level = lvl; wr_dur = DUR_W'(dur);
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic write_cfg(input int ch, input int len, input bit rep);
        @(negedge clk);
        cfg_en = 1'b1; cfg_ch = CH_W'(ch); cfg_len = 4'(len); cfg_repeat = rep;
        @(negedge clk);
        cfg_en = 1'b0;
    endtask

    task automatic pulse_start(input logic [NUM_CH-1:0] m);
        @(negedge clk);
        start = m;
        @(negedge clk);
        start = '0;
    endtask

    task automatic wait_phase(input int unsigned ph);
        int i = 0;
        while (m_ps != ph && i < 3 * DIV) begin
            @(negedge clk);
            i++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog timeout");
    end

    int unsigned cnt;
    int unsigned done_total;
    int          guard;

    initial begin
        // Reset held low
        wait_clk(3);
        check_val("rst_led", 32'(led), 32'hF);
        check_val("rst_busy", 32'(busy), 32'h0);
        check_val("rst_done", 32'(done), 32'h0);
        rst_n = 1'b1;

        // start with len == 0 is ignored
        pulse_start(4'b0001);
        wait_clk(3);
        check_val("len0_busy", 32'(busy), 32'h0);
        check_val("len0_led", 32'(led), 32'hF);

        // Repeating blink on ch0, plus an out-of-range length write
        write_seg(0, 0, 1'b0, 2);
        write_seg(0, 1, 1'b1, 10);
        write_seg(0, 2, 1'b0, 2);
        write_seg(0, 3, 1'b1, 2);
        write_cfg(0, 4, 1'b1);
        pulse_start(4'b0001);
        wait_clk(150);
        write_cfg(0, 9, 1'b0);
        wait_clk(200);
        check_val("ch0_busy", 32'(busy[0]), 32'h1);
        check_val("ch0_no_done", done_seen[0], 0);

        // One-shot on ch1
        write_seg(1, 0, 1'b1, 3);
        write_seg(1, 1, 1'b0, 1);
        write_cfg(1, 2, 1'b0);
        pulse_start(4'b0010);
        guard = 0;
        while (!done[1] && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check_val("ch1_done", 32'(done[1]), 32'h1);
        check_val("ch1_done_busy", 32'(busy[1]), 32'h0);
        check_val("ch1_done_led", 32'(led[1]), 32'h1);
        wait_clk(20);

        // stop on the one-shot final tick: no done
        @(negedge clk);
        start = 4'b0010;
        @(negedge clk);
        start = '0;
        cnt = 0;
        guard = 0;
        while (cnt < 4 && guard < 200) begin
            if (m_ps == DIV - 1) cnt++;
            if (cnt == 4) stop = 4'b0010;
            else @(negedge clk);
            guard++;
        end
        @(negedge clk);
        stop = '0;
        check_val("stopfin_busy", 32'(busy[1]), 32'h0);
        wait_clk(30);
        check_val("stopfin_no_done", done_seen[1], 1);

        // ch2: stop+start together, then restart mid segment 1
        write_seg(2, 0, 1'b1, 4);
        write_seg(2, 1, 1'b0, 4);
        write_cfg(2, 2, 1'b1);
        pulse_start(4'b0100);
        wait_clk(30);
        @(negedge clk);
        start = 4'b0100; stop = 4'b0100;
        @(negedge clk);
        start = '0; stop = '0;
        check_val("ss_busy2", 32'(busy[2]), 32'h0);
        check_val("ss_led2", 32'(led[2]), 32'h1);
        wait_clk(20);
        pulse_start(4'b0100);
        wait_clk(55);
        check_val("seg1_led2", 32'(led[2]), 32'h1);
        pulse_start(4'b0100);
        check_val("restart_led2", 32'(led[2]), 32'h0);
        check_val("restart_busy2", 32'(busy[2]), 32'h1);
        wait_clk(30);
        check_val("ch2_no_done", done_seen[2], 0);

        // ch3: dur 0 as one tick, live rewrite of segment 1
        write_seg(3, 0, 1'b1, 0);
        write_seg(3, 1, 1'b0, 5);
        write_cfg(3, 2, 1'b0);
        wait_phase(0);
        start = 4'b1000;
        @(negedge clk);
        start = '0;
        check_val("ch3_lit", 32'(led[3]), 32'h0);
        wr_en = 1'b1; wr_ch = 2'd3; wr_idx = 3'd1; wr_level = 1'b0; wr_dur = 16'd2;
        @(negedge clk);
        wr_en = 1'b0;
        wait_clk(60);
        check_val("ch3_done_once", done_seen[3], 1);

        // Async reset mid-run with all channels running
        write_cfg(1, 2, 1'b1);
        write_cfg(3, 2, 1'b1);
        pulse_start(4'b1111);
        wait_clk(25);
        check_val("all_busy", 32'(busy), 32'hF);
        done_total = done_seen[0] + done_seen[1] + done_seen[2] + done_seen[3];
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check_val("arst_led", 32'(led), 32'hF);
        check_val("arst_busy", 32'(busy), 32'h0);
        check_val("arst_done", 32'(done), 32'h0);
        #1 rst_n = 1'b1;
        pulse_start(4'b1111);
        wait_clk(50);
        check_val("post_rst_busy", 32'(busy), 32'h0);
        check_val("post_rst_no_done",
                  done_seen[0] + done_seen[1] + done_seen[2] + done_seen[3], done_total);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/led_pattern_seq.md
Name: led_pattern_seq

Overview:
- Multi-channel programmable LED blink sequencer. It generalises the fixed short/long blink generator into NUM_CH independent channels.
- Each channel plays a stored pattern of up to DEPTH segments. A segment is a level plus a duration in ticks. Patterns run one-shot or repeating.
- A shared prescaler derives the tick from the system clock.
- Sits between the control/status logic and the board LED pins; the pattern is loaded by the control FSM at runtime.

Parameters:
- CLK_FREQ, 48_000_000, system clock frequency in Hz.
- TICK_HZ, 1000, tick rate in Hz (1 ms tick). DIV = CLK_FREQ/TICK_HZ, must be >= 2.
- NUM_CH, 4, number of LED channels, >= 1.
- DEPTH, 8, maximum segments per channel pattern, >= 2.
- DUR_W, 16, segment duration width in ticks.
- LED_ACTIVE_LOW, 1, 1 means the pin is driven 0 when lit.
- Derived widths: CH_W = max(1, clog2(NUM_CH)); IDX_W = max(1, clog2(DEPTH)).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- wr_en  in  1  pattern memory write strobe.
- wr_ch  in  CH_W  target channel.
- wr_idx  in  IDX_W  segment index.
- wr_level  in  1  segment level, 1 = lit.
- wr_dur  in  DUR_W  segment duration in ticks.
- cfg_en  in  1  channel config write strobe.
- cfg_ch  in  CH_W  target channel.
- cfg_len  in  IDX_W+1  number of active segments, 0..DEPTH.
- cfg_repeat  in  1  1 = loop pattern, 0 = one-shot.
- start  in  NUM_CH  per-channel start pulse.
- stop  in  NUM_CH  per-channel stop pulse.
- led  out  NUM_CH  LED pins, polarity per LED_ACTIVE_LOW.
- busy  out  NUM_CH  channel running.
- done  out  NUM_CH  one-cycle pulse on one-shot completion.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - led = all OFF (OFF = LED_ACTIVE_LOW); busy = 0; done = 0.
  - Prescaler = 0; all len/repeat = 0; pattern memory cleared to level 0, dur 0; every channel in IDLE.
- Prescaler:
  - Free-running counter 0..DIV-1 from reset release.
  - tick is high for one clk when counter == DIV-1. One tick is shared by all channels.
- Writes:
  - wr_en and cfg_en take effect on the clock edge and are legal while a channel runs.
  - Writes with out-of-range wr_ch, wr_idx, cfg_ch, or cfg_len > DEPTH are ignored.
- Per-channel FSM, states IDLE and RUN. Each channel holds idx and a remaining-ticks counter rem.
- IDLE:
  - On start[c] with len > 0: go to RUN, idx = 0, rem = max(dur[0], 1).
  - led[c] shows level[0] and busy[c] = 1 on the next cycle.
  - start with len == 0 is ignored.
- RUN, on tick:
  - If rem > 1: rem = rem - 1.
  - Otherwise end the segment. If idx+1 >= len:
    - repeat = 1: reload idx = 0.
    - repeat = 0: go to IDLE; led OFF, busy = 0 and done[c] = 1 all on the same cycle.
  - If idx+1 < len: idx = idx + 1 and rem = max(dur[idx+1], 1).
  - The loaded level drives led on the cycle after the tick.
- Duration rules:
  - dur == 0 is treated as 1 tick.
  - A segment lasts exactly dur ticks counted from the first tick after it is loaded.
- Writes during RUN:
  - A segment rewritten while RUN is used when it is next loaded.
  - A len change is checked at the next segment end (>= compare), so shrinking len below idx+1 ends or wraps at that boundary.
- start[c] while RUN restarts at idx 0 with rem reloaded; no done pulse.
- stop[c]:
  - In any state: go to IDLE next cycle; led OFF, busy = 0, no done.
  - stop and start on the same cycle: stop wins.
  - stop on the same cycle as the one-shot final tick: stop wins, no done.
- Channels are fully independent; simultaneous events on different channels do not interact.
- led, busy and done are registered outputs with no combinational path from inputs.

Test Plan:
All scenarios use CLK_FREQ=1000, TICK_HZ=100 (DIV=10), NUM_CH=4, DEPTH=8, DUR_W=16, LED_ACTIVE_LOW=1.
- Reset: power up and hold rst_n low → led=4'b1111, busy=0, done=0. Release, start ch0 with len=0 → no change.
- Repeating blink: ch0 segments {(0,2),(1,10),(0,2),(1,2)}, len=4, repeat=1, start → led[0] pattern 1 for 20 clk, 0 for 100, 1 for 20, 0 for 20, repeating; busy[0] stays 1, done never asserts.
- One-shot: ch1 {(1,3),(0,1)}, len=2, repeat=0 → led[1]=0 for 3 ticks, then 1 for 1 tick. On the final tick +1 cycle: done[1]=1 for one clk, busy[1]=0, led[1]=1.
- Control: ch2 running; stop[2] and start[2] same cycle → IDLE, led[2]=1, no done. Later start[2] mid-segment 1 → restarts at segment 0.
- dur=0 / live edit: ch3 {(1,0),(0,5)} → segment 0 lasts 1 tick. Rewrite segment 1 to dur=2 during segment 0 → segment 1 lasts 2 ticks.
- Async reset mid-run: all 4 channels running, rst_n pulsed low between edges → led=4'b1111 and busy=0 before the next clk edge; no done pulse afterwards.
